// File: rtl/ycbcr2rgb_pipe.sv
// ycbcr2rgb_pipe: three-stage pipelined full-range BT.601 (JFIF) YCbCr -> RGB
// converter with valid/ready handshaking on both sides and an output pixel counter.
//
// Ports:
//   clk_i        : clock, all state changes on its rising edge
//   rst_ni       : asynchronous active-low reset
//   clear_i      : synchronous flush of the pipeline valid bits and the counter
//   in_valid_i   : input pixel valid
//   in_ready_o   : input pixel accepted this cycle
//   in_data_i    : input pixel {y, cb, cr}
//   out_valid_o  : output pixel valid
//   out_ready_i  : downstream accepts the output pixel
//   out_data_o   : converted pixel {r, g, b}
//   pix_cnt_o    : count of completed output handshakes, wraps

package rgb2ycbcr_package;
    parameter int CHANNEL_WIDTH = 8;

    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0] y;
        logic [CHANNEL_WIDTH-1:0] cb;
        logic [CHANNEL_WIDTH-1:0] cr;
    } ycbcr_struct;

    typedef struct packed {
        logic [CHANNEL_WIDTH-1:0] r;
        logic [CHANNEL_WIDTH-1:0] g;
        logic [CHANNEL_WIDTH-1:0] b;
    } rgb_struct;
endpackage

module ycbcr2rgb_pipe
    import rgb2ycbcr_package::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  ycbcr_struct          in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output rgb_struct            out_data_o,
    output logic [CNT_WIDTH-1:0] pix_cnt_o
);

    localparam int W  = CHANNEL_WIDTH;
    localparam int PW = 24;             // product width, holds 29032*128 signed

    localparam logic signed [PW-1:0]   C_R_CR = 24'sd22970;
    localparam logic signed [PW-1:0]   C_G_CB = -24'sd5638;
    localparam logic signed [PW-1:0]   C_G_CR = -24'sd11700;
    localparam logic signed [PW-1:0]   C_B_CB = 24'sd29032;
    localparam logic signed [PW+1:0]   RND    = 26'sd8192;
    localparam logic signed [PW+1:0]   MAXV   = 26'sd255;

    logic v1, v2, v3;
    logic ld1, ld2, ld3;
    logic in_hs;

    // Each stage loads when empty or when its contents move on downstream.
    assign ld3        = !v3 || out_ready_i;
    assign ld2        = !v2 || ld3;
    assign ld1        = !v1 || ld2;
    assign in_ready_o = ld1 && !clear_i;
    assign in_hs      = in_valid_i && in_ready_o;
    assign out_valid_o = v3;

    // Stage 1: Y and chroma offsets
    logic [W-1:0]      y1;
    logic signed [W:0] dcb1, dcr1;

    always_ff @(posedge clk_i) begin
        if (in_hs) begin
            y1   <= in_data_i.y;
            dcb1 <= $signed({1'b0, in_data_i.cb}) - 9'sd128;
            dcr1 <= $signed({1'b0, in_data_i.cr}) - 9'sd128;
        end
    end

    // Stage 2: products
    logic signed [PW-1:0] dcb_x, dcr_x;
    logic signed [PW-1:0] p_rcr2, p_gcb2, p_gcr2, p_bcb2;
    logic [W-1:0]         y2;

    assign dcb_x = {{(PW-W-1){dcb1[W]}}, dcb1};
    assign dcr_x = {{(PW-W-1){dcr1[W]}}, dcr1};

    always_ff @(posedge clk_i) begin
        if (ld2 && v1) begin
            y2     <= y1;
            p_rcr2 <= dcr_x * C_R_CR;
            p_gcb2 <= dcb_x * C_G_CB;
            p_gcr2 <= dcr_x * C_G_CR;
            p_bcb2 <= dcb_x * C_B_CB;
        end
    end

    // Stage 3 combinational part: round (floor of acc+0.5), add Y, saturate.
    function automatic logic [W-1:0] round_clamp(input logic signed [PW:0] acc,
                                                 input logic [W-1:0]       y);
        logic signed [PW+1:0] t;
        t = $signed({acc[PW], acc});
        t = (t + RND) >>> 14;
        t = t + $signed({{(PW+2-W){1'b0}}, y});
        if (t[PW+1])
            round_clamp = '0;
        else if (t > MAXV)
            round_clamp = '1;
        else
            round_clamp = t[W-1:0];
    endfunction

    logic signed [PW:0] acc_r, acc_g, acc_b;
    rgb_struct          rgb_d;

    always_comb begin
        acc_r   = $signed({p_rcr2[PW-1], p_rcr2});
        acc_g   = $signed({p_gcb2[PW-1], p_gcb2}) + $signed({p_gcr2[PW-1], p_gcr2});
        acc_b   = $signed({p_bcb2[PW-1], p_bcb2});
        rgb_d.r = round_clamp(acc_r, y2);
        rgb_d.g = round_clamp(acc_g, y2);
        rgb_d.b = round_clamp(acc_b, y2);
    end

    // Valid bits, output register and counter; clear overrides any load or count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            out_data_o <= '0;
            pix_cnt_o  <= '0;
        end else if (clear_i) begin
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            pix_cnt_o  <= '0;
        end else begin
            if (ld1) v1 <= in_valid_i;
            if (ld2) v2 <= v1;
            if (ld3) v3 <= v2;
            if (ld3 && v2) out_data_o <= rgb_d;
            if (v3 && out_ready_i) pix_cnt_o <= pix_cnt_o + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_ycbcr2rgb_pipe.sv
// Scoreboard testbench for ycbcr2rgb_pipe (instantiated with a 4-bit counter).
module tb_ycbcr2rgb_pipe;

    logic        clk_i;
    logic        rst_ni;
    logic        clear_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [23:0] in_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [23:0] out_data_o;
    logic [3:0]  pix_cnt_o;

    ycbcr2rgb_pipe #(.CNT_WIDTH(4)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_data_i   (in_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .pix_cnt_o   (pix_cnt_o)
    );

    typedef struct {
        logic [23:0] d;
        int          cyc;
        bit          lat;
    } exp_t;

    exp_t        q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rmode = 0;       // 0: ready high, 1: random, 2: ready low
    logic [23:0] cur_exp = '0;
    bit          lat_chk = 1'b0;

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic chk(input bit ok, input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v < 0) return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    function automatic logic [23:0] ref_conv(input logic [23:0] p);
        int y, dcb, dcr, r, g, b;
        logic [7:0] r8, g8, b8;
        y   = int'(p[23:16]);
        dcb = int'(p[15:8]) - 128;
        dcr = int'(p[7:0]) - 128;
        r = clamp8(y + ((22970 * dcr + 8192) >>> 14));
        g = clamp8(y + ((-5638 * dcb - 11700 * dcr + 8192) >>> 14));
        b = clamp8(y + ((29032 * dcb + 8192) >>> 14));
        r8 = r[7:0];
        g8 = g[7:0];
        b8 = b[7:0];
        return {r8, g8, b8};
    endfunction

    // out_ready driver
    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (rmode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = 1'b0;
            endcase
        end
    end

    // Monitor / scoreboard
    initial begin
        logic [3:0]  exp_cnt;
        bit          held;
        bit          post_flush;
        logic [23:0] held_d;
        exp_t        e;
        exp_cnt    = '0;
        held       = 1'b0;
        post_flush = 1'b0;
        held_d     = '0;
        forever begin
            @(negedge clk_i);
            cyc++;
            if (!rst_ni) begin
                chk(out_valid_o == 1'b0, "rst_out_valid", 32'(out_valid_o), 0);
                chk(pix_cnt_o == 4'd0, "rst_pix_cnt", 32'(pix_cnt_o), 0);
                chk(out_data_o == 24'd0, "rst_out_data", 32'(out_data_o), 0);
                q.delete();
                exp_cnt = '0; held = 1'b0; post_flush = 1'b1;
            end else if (clear_i) begin
                chk(in_ready_o == 1'b0, "clear_in_ready", 32'(in_ready_o), 0);
                q.delete();
                exp_cnt = '0; held = 1'b0; post_flush = 1'b1;
            end else begin
                if (post_flush) begin
                    chk(out_valid_o == 1'b0, "flush_out_valid", 32'(out_valid_o), 0);
                    chk(in_ready_o == 1'b1, "flush_in_ready", 32'(in_ready_o), 1);
                    post_flush = 1'b0;
                end
                chk(pix_cnt_o == exp_cnt, "pix_cnt", 32'(pix_cnt_o), 32'(exp_cnt));
                if (held)
                    chk(out_valid_o && out_data_o == held_d, "stall_hold",
                        32'(out_data_o), 32'(held_d));
                if (out_valid_o && out_ready_i) begin
                    chk(q.size() != 0, "unexpected_out", 32'(out_data_o), 0);
                    if (q.size() != 0) begin
                        e = q.pop_front();
                        chk(out_data_o == e.d, "out_data", 32'(out_data_o), 32'(e.d));
                        if (e.lat)
                            chk(cyc - e.cyc == 3, "latency", 32'(cyc - e.cyc), 3);
                        else
                            chk(cyc - e.cyc >= 3, "latency_min", 32'(cyc - e.cyc), 3);
                    end
                    exp_cnt = exp_cnt + 4'd1;
                end
                if (!out_ready_i)
                    chk(q.size() <= 3, "stall_occupancy", 32'(q.size()), 3);
                held   = out_valid_o && !out_ready_i;
                held_d = out_data_o;
                if (in_valid_i && in_ready_o) begin
                    e.d = cur_exp; e.cyc = cyc; e.lat = lat_chk;
                    q.push_back(e);
                end
            end
        end
    end

    task automatic send(input logic [23:0] pix, input logic [23:0] exp);
        int n;
        n = 0;
        in_valid_i = 1'b1;
        in_data_i  = pix;
        cur_exp    = exp;
        do begin
            @(negedge clk_i);
            n++;
        end while (!in_ready_o && n < 200);
        chk(in_ready_o == 1'b1, "send_accept", 32'(in_ready_o), 1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        chk(q.size() == 0, "drain", 32'(q.size()), 0);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [23:0] pix;
        rst_ni     = 1'b0;
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        in_data_i  = '0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i);
        #1;

        // Grey then black, back to back, no stall
        rmode = 0; lat_chk = 1'b1;
        send(24'h808080, 24'h808080);
        send(24'h008080, 24'h000000);
        drain();
        chk(pix_cnt_o == 4'd2, "cnt_after_two", 32'(pix_cnt_o), 2);

        // Saturation and mid-range vectors
        send(24'hFFFFFF, 24'hFF79FF);
        send(24'h000000, 24'h008700);
        send(24'h6480C8, 24'hC93164);   // Y=100 Cb=128 Cr=200
        send(24'h323C80, 24'h324900);   // Y=50 Cb=60 Cr=128
        drain();

        // Random pixels under random backpressure
        rmode = 1; lat_chk = 1'b0;
        for (int i = 0; i < 10; i++) begin
            pix = 24'($urandom);
            send(pix, ref_conv(pix));
        end
        send(24'hFFFFFF, 24'hFF79FF);
        send(24'h000000, 24'h008700);
        rmode = 0;
        drain();

        // Counter wrap: 17 pixels on a 4-bit counter
        clear_i = 1'b1;
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        lat_chk = 1'b1;
        for (int i = 0; i < 17; i++) begin
            pix = 24'($urandom);
            send(pix, ref_conv(pix));
        end
        drain();
        chk(pix_cnt_o == 4'd1, "cnt_wrap", 32'(pix_cnt_o), 1);

        // Clear with three pixels in flight and a simultaneous input
        rmode = 2; lat_chk = 1'b0;
        for (int i = 0; i < 3; i++) send(24'h808080, 24'h808080);
        repeat (2) @(posedge clk_i);
        #1;
        clear_i    = 1'b1;
        in_valid_i = 1'b1;
        in_data_i  = 24'h123456;
        cur_exp    = ref_conv(24'h123456);
        @(posedge clk_i);
        #1;
        clear_i    = 1'b0;
        in_valid_i = 1'b0;
        rmode = 0;
        repeat (8) @(posedge clk_i);
        #1;
        chk(pix_cnt_o == 4'd0, "cnt_after_clear", 32'(pix_cnt_o), 0);

        // Reset mid-stream
        send(24'hFFFFFF, 24'hFF79FF);
        drain();
        rmode = 2;
        for (int i = 0; i < 3; i++) send(24'h000000, 24'h008700);
        #2;
        rst_ni     = 1'b0;
        in_valid_i = 1'b1;
        in_data_i  = 24'h654321;
        @(posedge clk_i);
        #1;
        rst_ni     = 1'b1;
        in_valid_i = 1'b0;
        rmode = 0;
        repeat (8) @(posedge clk_i);
        #1;
        chk(pix_cnt_o == 4'd0, "cnt_after_reset", 32'(pix_cnt_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
